// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage iterative multiply/divide unit with HI/LO registers
// Radix-2 shift-add multiply and restoring divide share one 2*XLEN accumulator.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [2*XLEN-1:0]     acc;
    logic [XLEN-1:0]       b_reg;
    logic [XLEN-1:0]       a_orig;
    logic                  is_div, neg_q, neg_r, div0;

    logic                  accept;
    logic                  signed_op;
    logic [XLEN-1:0]       a_mag, b_mag;
    logic [XLEN:0]         mul_sum;
    logic [2*XLEN-1:0]     mul_nxt;
    logic [XLEN:0]         div_trial, div_diff;
    logic                  div_ge;
    logic [2*XLEN-1:0]     div_nxt;
    logic [2*XLEN-1:0]     prod;
    logic [XLEN-1:0]       quo, rem;

    always_comb begin
        accept    = (state == IDLE) && start && !flush;
        signed_op = !op[0];
        a_mag     = (signed_op && src_a[XLEN-1]) ? -src_a : src_a;
        b_mag     = (signed_op && src_b[XLEN-1]) ? -src_b : src_b;

        // Multiply: conditionally add multiplicand to upper half, then shift right.
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b_reg};
        mul_nxt = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

        // Divide: upper half is the partial remainder, lower half shifts the dividend out
        // and the quotient bits in. The trial keeps the bit shifted out of the remainder.
        div_trial = acc[2*XLEN-1:XLEN-1];
        div_ge    = div_trial >= {1'b0, b_reg};
        div_diff  = div_trial - {1'b0, b_reg};
        div_nxt   = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
                     acc[XLEN-2:0], div_ge};

        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !op[2]) state_nxt = CALC;
            CALC: begin
                if (flush)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(XLEN-1))
                    state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            b_reg  <= '0;
            a_orig <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                acc    <= {{XLEN{1'b0}}, a_mag};
                                b_reg  <= b_mag;
                                a_orig <= src_a;
                                is_div <= op[1];
                                neg_q  <= signed_op && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                                neg_r  <= signed_op && src_a[XLEN-1];
                                div0   <= op[1] && (src_b == '0);
                            end
                            3'b100:  hi <= src_a;
                            3'b101:  lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (flush) begin
                        cnt <= '0;
                    end else begin
                        acc <= is_div ? div_nxt : mul_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    cnt <= '0;
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            {hi, lo} <= prod;
                        end else if (div0) begin
                            hi <= a_orig;
                            lo <= '1;
                        end else begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv
// Expected HI/LO results are queued at issue; a monitor pops them on each done pulse.
module tb_ex_muldiv;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      op = 3'b000;
    logic [XLEN-1:0] src_a = '0;
    logic [XLEN-1:0] src_b = '0;
    logic            busy, done;
    logic [XLEN-1:0] hi, lo;

    int vectors = 0;
    int errors  = 0;
    logic [63:0] sb[$];

    ex_muldiv #(.XLEN(XLEN), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_done: hi=%h lo=%h with nothing expected", hi, lo);
                end else begin
                    check("hilo", {hi, lo}, sb.pop_front());
                end
            end
            if (start && busy) begin
                vectors++;
                errors++;
                $display("FAIL start_while_busy: start=1 busy=1, required start=0");
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int cycles;
        sb.push_back({exp_hi, exp_lo});
        issue(o, a, b);
        cycles = 0;
        while (busy && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({name, "_busy_cycles"}, 64'(cycles), 64'd33);
        @(negedge clk);
        #1;
        check({name, "_done_seen"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult_neg",   3'b000, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg",    3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero",  3'b011, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_zero",   3'b010, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_ovf",    3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_negb",   3'b010, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
        run_op("mult_min",   3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("divu_big",   3'b011, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'h7FFF_FFFF);

        issue(3'b101, 32'h1234_5678, 32'd0);
        check("mtlo_lo", {32'd0, lo}, {32'd0, 32'h1234_5678});
        check("mtlo_busy", {62'd0, busy, done}, 64'd0);
        issue(3'b100, 32'h0BAD_F00D, 32'd0);
        check("mthi_hi", {32'd0, hi}, {32'd0, 32'h0BAD_F00D});

        issue(3'b000, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_calc_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_calc_hilo", {hi, lo}, {32'h0BAD_F00D, 32'h1234_5678});

        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op    = 3'b100;
        src_a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        check("flush_start_hi", {hi, lo}, {32'h0BAD_F00D, 32'h1234_5678});

        issue(3'b110, 32'hCAFE_0000, 32'd1);
        check("undef_op_busy", {63'd0, busy}, 64'd0);
        check("undef_op_hilo", {hi, lo}, {32'h0BAD_F00D, 32'h1234_5678});

        issue(3'b011, 32'd100, 32'd3);
        repeat (32) @(posedge clk);
        #1;
        check("fin_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_fin_busy", {62'd0, busy, done}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flush_fin_hilo", {hi, lo}, {32'h0BAD_F00D, 32'h1234_5678});

        issue(3'b000, 32'd5, 32'd5);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_reset_busy", {62'd0, busy, done}, 64'd0);
        check("midop_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult_after_reset", 3'b000, 32'd2, 32'd3, 32'd0, 32'd6);

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
